mem_loader: RTL

- Writer side of the convolution memory interface.
- Accepts a serial byte stream over a valid/ready handshake and fills two buffers: a 4x4 input-tile buffer (16 bytes) and a 3x3 filter buffer (9 bytes).
- Presents both buffers as parallel flat buses to the convolution datapath, in the same element order the memory block uses (input_data0..15, filter_data0..8).
- Sits between the host/stream source and the convolution engine. Signals completion so the engine can start.

---
 rtl/conv_pkg.sv | 17 +
 rtl/mem_loader_regfile.sv | 29 ++
 rtl/mem_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Constants and FSM state encoding shared by the convolution memory,
// loader and datapath blocks.
package conv_pkg;

    localparam int DATA_W    = 8;
    localparam int IN_DEPTH  = 16;
    localparam int FLT_DEPTH = 9;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_IN  = 3'd1,
        LOAD_FLT = 3'd2,
        CHECK    = 3'd3,
        DONE     = 3'd4
    } ld_state_t;

endpackage

// File: rtl/mem_loader_regfile.sv
// DEPTH x DATA_W write-indexed register bank with a flat read bus and
// asynchronous active-low clear.
module mem_loader_regfile #(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 8,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DEPTH*DATA_W-1:0] flat
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_el
        logic [DATA_W-1:0] q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= '0;
            else if (we && waddr == AW'(i))
                q <= wdata;
        end

        assign flat[i*DATA_W +: DATA_W] = q;
    end

endmodule

// File: rtl/mem_loader.sv
// Stream-to-buffer loader: fills a 4x4 input tile and a 3x3 filter from a
// valid/ready byte stream. Optional trailing checksum byte: MEM_LOADER_CKSUM_EN.
module mem_loader #(
    parameter int DATA_W    = conv_pkg::DATA_W,
    parameter int IN_DEPTH  = conv_pkg::IN_DEPTH,
    parameter int FLT_DEPTH = conv_pkg::FLT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        s_valid,
    input  logic [DATA_W-1:0]           s_data,
    output logic                        s_ready,
    output logic [IN_DEPTH*DATA_W-1:0]  input_flat,
    output logic [FLT_DEPTH*DATA_W-1:0] filter_flat,
    output logic                        busy,
    output logic                        load_done,
    output logic                        err
);
    import conv_pkg::*;

    localparam int CNT_W = $clog2(IN_DEPTH);

    ld_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             we_in;
    logic             we_flt;

    // Abort takes precedence over a coincident transfer, so an aborted
    // cycle never writes a byte.
    assign xfer   = s_valid && s_ready && !abort;
    assign we_in  = xfer && (state == LOAD_IN);
    assign we_flt = xfer && (state == LOAD_FLT);

`ifdef MEM_LOADER_CKSUM_EN
    logic [DATA_W-1:0] sum;
    logic              err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
`ifdef MEM_LOADER_CKSUM_EN
            sum       <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD_IN;
                        cnt       <= '0;
                        s_ready   <= 1'b1;
                        busy      <= 1'b1;
                        load_done <= 1'b0;
`ifdef MEM_LOADER_CKSUM_EN
                        sum       <= '0;
                        err_q     <= 1'b0;
`endif
                    end
                end
                LOAD_IN: begin
                    if (abort) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                    end else if (xfer) begin
`ifdef MEM_LOADER_CKSUM_EN
                        sum <= sum + s_data;
`endif
                        if (cnt == CNT_W'(IN_DEPTH - 1)) begin
                            state <= LOAD_FLT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_FLT: begin
                    if (abort) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                    end else if (xfer) begin
`ifdef MEM_LOADER_CKSUM_EN
                        sum <= sum + s_data;
`endif
                        if (cnt == CNT_W'(FLT_DEPTH - 1)) begin
                            cnt <= '0;
`ifdef MEM_LOADER_CKSUM_EN
                            state <= CHECK;
`else
                            state     <= DONE;
                            s_ready   <= 1'b0;
                            busy      <= 1'b0;
                            load_done <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`ifdef MEM_LOADER_CKSUM_EN
                CHECK: begin
                    if (abort) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                    end else if (xfer) begin
                        state     <= DONE;
                        s_ready   <= 1'b0;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
                        err_q     <= (s_data != sum);
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    mem_loader_regfile #(
        .DEPTH (IN_DEPTH),
        .DATA_W(DATA_W)
    ) u_in_buf (
        .clk  (clk),
        .rst_n(rst),
        .we   (we_in),
        .waddr(cnt),
        .wdata(s_data),
        .flat (input_flat)
    );

    mem_loader_regfile #(
        .DEPTH (FLT_DEPTH),
        .DATA_W(DATA_W)
    ) u_flt_buf (
        .clk  (clk),
        .rst_n(rst),
        .we   (we_flt),
        .waddr(cnt),
        .wdata(s_data),
        .flat (filter_flat)
    );

endmodule
